// File: rtl/neuron_pkg.sv
// +--------------------------------------------------------------------------+
// | Module : neuron_pkg                                                      |
// | Brief  : Shared state encoding and saturating arithmetic helpers for     |
// |          the fixed-point neuron layer.                                   |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FINAL = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Operands are held in 64 bits; all layer values stay far below 2^62, so the add cannot overflow.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int                 w);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (s > hi)      return hi;
        else if (s < lo) return lo;
        else             return s;
    endfunction

    function automatic logic signed [63:0] clamp(input logic signed [63:0] v,
                                                 input int                 from_w,
                                                 input int                 to_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        if (from_w <= to_w) return v;
        hi = (64'sd1 <<< (to_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (to_w - 1));
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

    function automatic logic signed [63:0] relu(input logic signed [63:0] v);
        return (v < 64'sd0) ? 64'sd0 : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/neuron_lane.sv
// +--------------------------------------------------------------------------+
// | Module : neuron_lane                                                     |
// | Brief  : One neuron: weight/bias store, multiply-shift, saturating       |
// |          accumulator, bias/clamp/activation (ReLU when NEURON_RELU_EN).  |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module neuron_lane
    import neuron_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int FRAC   = 8,
    parameter int ACC_W  = 32,
    parameter int N_IN   = 4,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DEPTH-1:0]  wdata,
    input  logic [DEPTH-1:0]  x_data,
    input  logic [ADDR_W-1:0] idx,
    input  logic              beat,
    input  logic              first,
    input  logic              fin,
    output logic [DEPTH-1:0]  y
);

    localparam logic [ADDR_W-1:0] c_bias_addr = ADDR_W'(N_IN);

    logic signed [DEPTH-1:0]   r_mem [N_IN+1];
    logic signed [ACC_W-1:0]   r_acc;
    logic        [DEPTH-1:0]   r_y;

    logic signed [2*DEPTH-1:0] w_prod;
    logic signed [2*DEPTH-1:0] w_shift;
    logic signed [63:0]        w_term;
    logic signed [63:0]        w_acc_base;
    logic signed [63:0]        w_res;
    logic signed [63:0]        w_cl;
    logic signed [63:0]        w_out;

    // Storage survives reset; a write in the same cycle as a beat lands after the read.
    always_ff @(posedge clk) begin
        if (we && (addr <= c_bias_addr)) begin
            r_mem[addr] <= $signed(wdata);
        end
    end

    assign w_prod     = $signed(x_data) * r_mem[idx];
    assign w_shift    = w_prod >>> FRAC;
    assign w_term     = sat_add(64'(w_shift), 64'sd0, ACC_W);
    assign w_acc_base = first ? 64'sd0 : 64'(r_acc);
    assign w_res      = sat_add(64'(r_acc), 64'(r_mem[c_bias_addr]), ACC_W);
    assign w_cl       = clamp(w_res, ACC_W, DEPTH);

`ifdef NEURON_RELU_EN
    assign w_out = relu(w_cl);
`else
    assign w_out = w_cl;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_y   <= '0;
        end else begin
            if (beat) begin
                r_acc <= ACC_W'(sat_add(w_acc_base, w_term, ACC_W));
            end
            if (fin) begin
                r_y <= DEPTH'(w_out);
            end
        end
    end

    assign y = r_y;

endmodule

`default_nettype wire

// File: rtl/neuron_layer.sv
// +--------------------------------------------------------------------------+
// | Module : neuron_layer                                                    |
// | Brief  : LANES fixed-point neurons sharing one valid/ready input stream; |
// |          NEURON_RELU_EN selects ReLU activation in every lane.           |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module neuron_layer
    import neuron_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int FRAC   = 8,
    parameter int ACC_W  = 32,
    parameter int N_IN   = 4,
    parameter int LANES  = 2,
    parameter int LANE_W = (LANES > 1) ? $clog2(LANES) : 1,
    parameter int ADDR_W = $clog2(N_IN + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   w_we,
    input  logic [LANE_W-1:0]      w_lane,
    input  logic [ADDR_W-1:0]      w_addr,
    input  logic [DEPTH-1:0]       w_data,
    input  logic                   x_valid,
    output logic                   x_ready,
    input  logic [DEPTH-1:0]       x_data,
    output logic                   y_valid,
    input  logic                   y_ready,
    output logic [LANES*DEPTH-1:0] y_data,
    output logic                   busy
);

    localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(N_IN - 1);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_idx;
    logic                w_beat;
    logic                w_first;
    logic                w_fin;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            if (w_beat) begin
                r_idx <= (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;
            end else if (r_state == OUT) begin
                r_idx <= '0;
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        x_ready = 1'b0;
        y_valid = 1'b0;
        case (r_state)
            IDLE, ACCUM: begin
                x_ready = 1'b1;
                if (x_valid) begin
                    w_next = (r_idx == c_last_idx) ? FINAL : ACCUM;
                end
            end
            FINAL: w_next = OUT;
            OUT: begin
                y_valid = 1'b1;
                if (y_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_beat  = x_valid && x_ready;
    assign w_first = (r_state == IDLE);
    assign w_fin   = (r_state == FINAL);
    assign busy    = (r_state != IDLE);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic w_lane_we;
        assign w_lane_we = w_we && (r_state == IDLE) && (w_lane == LANE_W'(k));

        neuron_lane #(
            .DEPTH  (DEPTH),
            .FRAC   (FRAC),
            .ACC_W  (ACC_W),
            .N_IN   (N_IN),
            .ADDR_W (ADDR_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .we     (w_lane_we),
            .addr   (w_addr),
            .wdata  (w_data),
            .x_data (x_data),
            .idx    (r_idx),
            .beat   (w_beat),
            .first  (w_first),
            .fin    (w_fin),
            .y      (y_data[k*DEPTH +: DEPTH])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_neuron_layer.sv
// +--------------------------------------------------------------------------+
// | Module : tb_neuron_layer                                                 |
// | Brief  : Scoreboard bench for neuron_layer (DEPTH=16, FRAC=8, N_IN=4,    |
// |          LANES=2) with hand-computed vectors.                            |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_neuron_layer;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_we;
    logic [0:0]  w_lane;
    logic [2:0]  w_addr;
    logic [15:0] w_data;
    logic        x_valid;
    logic        x_ready;
    logic [15:0] x_data;
    logic        y_valid;
    logic        y_ready;
    logic [31:0] y_data;
    logic        busy;

    neuron_layer #(
        .DEPTH (16), .FRAC (8), .ACC_W (32), .N_IN (4), .LANES (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .w_we    (w_we),
        .w_lane  (w_lane),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .x_data  (x_data),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .y_data  (y_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          last_beat_cyc = 0;
    logic        prev_y_valid  = 1'b0;
    logic [31:0] sb [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Output monitor: latency on each new result, data against the scoreboard on handshake.
    always @(negedge clk) begin
        if (y_valid && !prev_y_valid) begin
            check("latency", 32'(cyc - last_beat_cyc), 32'd2);
        end
        if (y_valid && y_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", y_data, 32'hDEAD_BEEF);
            end else begin
                check("y_data", y_data, sb.pop_front());
            end
        end
        prev_y_valid <= y_valid;
    end

    task automatic wr(input logic lane, input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        w_we = 1'b1; w_lane = lane; w_addr = addr; w_data = data;
        @(posedge clk); #1;
        w_we = 1'b0;
    endtask

    task automatic load(input logic lane, input logic [15:0] w, input logic [15:0] b);
        for (int i = 0; i < 4; i++) wr(lane, 3'(i), w);
        wr(lane, 3'd4, b);
    endtask

    task automatic beat(input logic [15:0] d);
        int n;
        n = 0;
        @(negedge clk);
        x_valid = 1'b1; x_data = d;
        while (!x_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!x_ready) check("x_ready_timeout", 32'd0, 32'd1);
        last_beat_cyc = cyc;
        @(posedge clk); #1;
        x_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            check("output_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic run4(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d, input logic [31:0] exp);
        sb.push_back(exp);
        beat(a); beat(b); beat(c); beat(d);
        wait_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; w_we = 1'b0; w_lane = '0; w_addr = '0; w_data = '0;
        x_valid = 1'b0; x_data = '0; y_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_y_valid", 32'(y_valid), 32'd0);
        check("reset_busy",    32'(busy),    32'd0);
        check("reset_y_data",  y_data,       32'd0);
        check("reset_x_ready", 32'(x_ready), 32'd1);

        // Basic: 1.0 weights, bias 0.5 -> 1+2+3+4+0.5 = 10.5
        load(1'b0, 16'h0100, 16'h0080);
        load(1'b1, 16'h0100, 16'h0080);
        run4(16'h0100, 16'h0200, 16'h0300, 16'h0400, 32'h0A80_0A80);

        // Backpressure: result held with y_ready low
        y_ready = 1'b0;
        sb.push_back(32'h0A80_0A80);
        beat(16'h0100); beat(16'h0200); beat(16'h0300); beat(16'h0400);
        begin
            int n;
            n = 0;
            while (!y_valid && n < 20) begin @(negedge clk); n++; end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_y_valid", 32'(y_valid), 32'd1);
            check("bp_y_data",  y_data,       32'h0A80_0A80);
            check("bp_x_ready", 32'(x_ready), 32'd0);
        end
        y_ready = 1'b1;
        wait_out();
        check("bp_idle_busy",    32'(busy),    32'd0);
        check("bp_idle_x_ready", 32'(x_ready), 32'd1);

        // Reset mid-ACCUM after two beats
        beat(16'h0700); beat(16'h0500);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_y_valid", 32'(y_valid), 32'd0);
        check("midrst_busy",    32'(busy),    32'd0);
        run4(16'h0100, 16'h0200, 16'h0300, 16'h0400, 32'h0A80_0A80);

        // Write during ACCUM is dropped
        sb.push_back(32'h0A80_0A80);
        beat(16'h0100);
        wr(1'b0, 3'd0, 16'h7FFF);
        beat(16'h0200); beat(16'h0300); beat(16'h0400);
        wait_out();

        // Same write in IDLE takes effect: lane0 = 127.996+2+3+4+0.5 -> clamps to 0x7FFF
        wr(1'b0, 3'd0, 16'h7FFF);
        run4(16'h0100, 16'h0200, 16'h0300, 16'h0400, 32'h0A80_7FFF);

        // Clamp: max weights and samples
        load(1'b0, 16'h7FFF, 16'h0000);
        load(1'b1, 16'h7FFF, 16'h0000);
        run4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 32'h7FFF_7FFF);

        // Sign / activation: lane0 -1.0 weights, lane1 +1.0
        load(1'b0, 16'hFF00, 16'h0000);
        load(1'b1, 16'h0100, 16'h0000);
`ifdef NEURON_RELU_EN
        run4(16'h0100, 16'h0100, 16'h0100, 16'h0100, 32'h0400_0000);
`else
        run4(16'h0100, 16'h0100, 16'h0100, 16'h0100, 32'h0400_FC00);
`endif

        // Negative bias on a mixed-sign vector: 1 - 2 + 3 - 4 - 0.25 = -2.25
        load(1'b0, 16'h0100, 16'hFFC0);
        load(1'b1, 16'h0200, 16'h0000);
`ifdef NEURON_RELU_EN
        run4(16'h0100, 16'hFE00, 16'h0300, 16'hFC00, 32'h0000_0000);
`else
        run4(16'h0100, 16'hFE00, 16'h0300, 16'hFC00, 32'hFC00_FDC0);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
